// File: rtl/pong_logica.sv
// pong_logica: per-frame Pong game-state engine (ball, paddles, scores and serve/play/point/game-over FSM)
module pong_logica #(
  parameter int TICK_DIV     = 833333,
  parameter int BALL_STEP    = 2,
  parameter int PAD_STEP     = 4,
  parameter int PAUSE_FRAMES = 60,
  parameter int MAX_SCORE    = 9
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_iu,
  input  logic       btn_id,
  input  logic       btn_du,
  input  logic       btn_dd,
  input  logic       btn_saque,
  output logic [9:0] posx,
  output logic [9:0] posy,
  output logic [9:0] posbarraiy,
  output logic [9:0] posbarrady,
  output logic [3:0] puntos_i,
  output logic [3:0] puntos_d,
  output logic       fin,
  output logic [1:0] estado
);
  typedef enum logic [1:0] {SERVE = 2'd0, PLAY = 2'd1, POINT = 2'd2, OVER = 2'd3} state_t;
  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PW = (PAUSE_FRAMES > 1) ? $clog2(PAUSE_FRAMES) : 1;
  state_t        r_st;
  logic [CW-1:0] r_cnt;
  logic [PW-1:0] r_pause;
  logic [9:0]    r_x, r_y, r_pi, r_pd;
  logic [3:0]    r_si, r_sd;
  logic          r_fin, r_dx, r_dy;
  logic          w_tick, w_lhit, w_rhit, w_gl, w_gr, w_ndy, w_over;
  logic [10:0]   w_x, w_y, w_nx, w_ny, w_pi, w_pd;
  logic [9:0]    w_ybnd, w_npi, w_npd;
  function automatic logic [9:0] pad_move(input logic [9:0] p, input logic up, input logic dn);
    logic [10:0] w_p;
    w_p = {1'b0, p};
    if (up && !dn) return (w_p < 11'(PAD_STEP + 10)) ? 10'd10 : p - 10'(PAD_STEP);
    if (dn && !up) return (w_p + 11'(PAD_STEP) > 11'd370) ? 10'd370 : p + 10'(PAD_STEP);
    return p;
  endfunction
  // 11-bit position math keeps the subtractions from wrapping near the top/left borders
  always_comb begin
    w_tick = r_cnt == CW'(TICK_DIV - 1);
    w_x    = {1'b0, r_x};
    w_y    = {1'b0, r_y};
    w_pi   = {1'b0, r_pi};
    w_pd   = {1'b0, r_pd};
    w_nx   = r_dx ? w_x + 11'(BALL_STEP) : w_x - 11'(BALL_STEP);
    w_ny   = r_dy ? w_y + 11'(BALL_STEP) : w_y - 11'(BALL_STEP);
    w_ndy  = (w_ny < 11'd10) ? 1'b1 : (w_ny > 11'd458) ? 1'b0 : r_dy;
    w_ybnd = (w_ny < 11'd10) ? 10'd10 : (w_ny > 11'd458) ? 10'd458 : w_ny[9:0];
    w_lhit = !r_dx && (w_x + 11'd1 > 11'd40) && (w_nx + 11'd1 <= 11'd40) &&
             (w_y + 11'd11 >= w_pi) && (w_y + 11'd1 <= w_pi + 11'd100);
    w_rhit = r_dx && (w_x + 11'd11 < 11'd600) && (w_nx + 11'd11 >= 11'd600) &&
             (w_y + 11'd11 >= w_pd) && (w_y + 11'd1 <= w_pd + 11'd100);
    w_gl   = !w_lhit && !w_rhit && (w_nx <= 11'd10);
    w_gr   = !w_lhit && !w_rhit && (w_nx >= 11'd619);
    w_over = (r_si == 4'(MAX_SCORE)) || (r_sd == 4'(MAX_SCORE));
    w_npi  = pad_move(r_pi, btn_iu, btn_id);
    w_npd  = pad_move(r_pd, btn_du, btn_dd);
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_st    <= SERVE;
      r_cnt   <= '0;
      r_pause <= '0;
      r_x     <= 10'd314;
      r_y     <= 10'd234;
      r_pi    <= 10'd190;
      r_pd    <= 10'd190;
      r_si    <= '0;
      r_sd    <= '0;
      r_fin   <= 1'b0;
      r_dx    <= 1'b1;
      r_dy    <= 1'b1;
    end else begin
      r_cnt <= w_tick ? '0 : r_cnt + 1'b1;
      if (w_tick) begin
        r_pi <= w_npi;
        r_pd <= w_npd;
        case (r_st)
          SERVE: if (btn_saque) begin
            r_st <= PLAY;
            r_dy <= 1'b1;
          end
          PLAY: begin
            r_dy <= w_ndy;
            if (w_gl || w_gr) begin
              r_st    <= POINT;
              r_pause <= '0;
              r_x     <= 10'd314;
              r_y     <= 10'd234;
              r_dx    <= w_gr;
              if (w_gl && r_sd < 4'(MAX_SCORE)) r_sd <= r_sd + 4'd1;
              if (w_gr && r_si < 4'(MAX_SCORE)) r_si <= r_si + 4'd1;
            end else begin
              r_x  <= w_lhit ? 10'd39 : w_rhit ? 10'd588 : w_nx[9:0];
              r_y  <= w_ybnd;
              r_dx <= w_lhit ? 1'b1 : w_rhit ? 1'b0 : r_dx;
            end
          end
          POINT: if (r_pause == PW'(PAUSE_FRAMES - 1)) begin
            r_st  <= w_over ? OVER : SERVE;
            r_fin <= w_over;
          end else begin
            r_pause <= r_pause + 1'b1;
          end
          OVER: if (btn_saque) begin
            r_st  <= SERVE;
            r_si  <= '0;
            r_sd  <= '0;
            r_fin <= 1'b0;
          end
        endcase
      end
    end
  end
  assign posx       = r_x;
  assign posy       = r_y;
  assign posbarraiy = r_pi;
  assign posbarrady = r_pd;
  assign puntos_i   = r_si;
  assign puntos_d   = r_sd;
  assign fin        = r_fin;
  assign estado     = r_st;
endmodule
